fv_stream_buffer: RTL and testbench
===================================

// Module: fv_stream_buffer
// PURPOSE
//  Elastic buffer directly downstream of the FV bank memory controller.
//  Captures sos/eos-framed feature-vector bursts, which cannot be back-pressured, into a FIFO.
//  Delivers each word to the Edge PE named by its PE tag, using a valid/ready handshake per PE.
//  Raises stall_req so the FV memory controller issues no new stream request unless a full burst fits.
// PARAMETERS
//  FV_BW      16  FV data width (matches `FV_bandwidth)
//  NUM_PE     4   number of Edge PEs (matches `Num_Edge_PE); TAG_W = $clog2(NUM_PE)
//  DEPTH      8   FIFO entries, power of two, >= MAX_BURST
//  MAX_BURST  4   max words per burst (ceil(`Max_FV_num / `num_fv_line))
// PORTS
//  clk           in   1        clock
//  reset         in   1        synchronous, active-high reset
//  in_valid      in   1        word from FV bank controller this cycle
//  in_sos        in   1        first word of burst
//  in_eos        in   1        last word of burst (sos&eos = single-word burst)
//  in_PE_tag     in   TAG_W    destination Edge PE
//  in_FV_data    in   FV_BW    feature data
//  pe_valid      out  NUM_PE   one-hot: head word valid for PE[i]
//  pe_sos        out  1        head word sos (broadcast)
//  pe_eos        out  1        head word eos (broadcast)
//  pe_FV_data    out  FV_BW    head word data (broadcast)
//  pe_ready      in   NUM_PE   PE[i] accepts the head word
//  stall_req     out  1        free entries < MAX_BURST; upstream must not start a burst
//  count         out  $clog2(DEPTH)+1  current occupancy
//  err           out  1        sticky error flag (FV_BUF_ERR_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (sync, high):
//    - wr_ptr = rd_ptr = count = 0; pe_valid = 0; stall_req = 0; err = 0.
//    - FIFO contents are don't-care.
//    - A burst in flight is discarded; words arriving in the reset cycle are dropped.
//  - Entry {sos, eos, tag, data}; the FIFO memory is registered.
//  - Head outputs are driven from the registered head entry. No combinational path from in_* to pe_*.
//  - Latency: a word pushed in cycle N is visible at the head in N+1 at the earliest (FIFO empty).
//  - pe_valid[i] = !empty && (head.tag == i). pe_valid never has more than one bit set.
//  - pop = |(pe_valid & pe_ready). pe_ready of non-addressed PEs is ignored.
//  - Head is held stable until popped.
//  - push = in_valid && (!full || pop). The pointer advances mod DEPTH (wrap-around).
//  - in_valid while full and no pop: word dropped, count unchanged.
//  - Simultaneous push and pop: count unchanged. When empty, push-only applies (no same-cycle bypass).
//  - stall_req = (DEPTH - count) < MAX_BURST, computed from registered count only.
//  - Upstream samples stall_req only while idle. Once a burst has started it runs to eos regardless.
//  - Burst FSM (input side) tracks framing:
//    - IDLE -> IN_BURST on in_valid & in_sos & !in_eos.
//    - IN_BURST -> IDLE on in_valid & in_eos.
//    - sos&eos stays in IDLE.
//    - Every word is stored regardless of FSM state. The FSM feeds only the error checks.
// CONFIGURATION
//  - Optional feature, macro FV_BUF_ERR_EN. When defined, err is set and held until reset on any of:
//    - a word dropped (push while full, no pop);
//    - in_valid & !in_sos in IDLE;
//    - in_valid & in_sos in IN_BURST;
//    - in_PE_tag changes within a burst.
//  - When FV_BUF_ERR_EN is not defined: no checker logic, err = 0, and the burst FSM is removed.
// STRUCTURE
//  - Shared package: fv_buf_entry_t struct {sos, eos, PE_tag, FV_data} and burst state enum {IDLE, IN_BURST}.
//  - Package also holds localparams TAG_W and CNT_W.
//  - Sub-module fv_buf_fifo: generic sync FIFO with push/pop/full/empty/count, parameterised on entry type and DEPTH.
//  - Top level adds PE routing, stall_req and the checker.
// TESTING  (DEPTH=8, NUM_PE=4, MAX_BURST=4)
//  - 4-word burst, tag 2, data 0x11..0x44, pe_ready=4'b0100 held
//    -> pe_valid=4'b0100 from the cycle after the first push; 0x11..0x44 in order; sos on 0x11, eos on 0x44.
//  - Bursts for tags 1 then 3, pe_ready=4'b0010 only
//    -> tag-1 words drain; head holds the first tag-3 word with pe_valid=4'b1000 until pe_ready[3]=1.
//  - Fill 5 words, pe_ready=0
//    -> stall_req=1 once count=5; back to 0 after one pop (count=4).
//  - count=8, pe_ready=0, in_valid=1
//    -> word dropped, count stays 8, err=1 with FV_BUF_ERR_EN; err=0 without it.
//    - Same with pe_ready set to the head's tag -> push and pop, count stays 8, no error.
//  - Wrap: 20 single-word bursts (sos=eos=1) with random ready
//    -> all 20 delivered in order, pointers wrap, count returns to 0.
//  - Reset asserted mid-burst at count=3
//    -> next cycle count=0, pe_valid=0, stall_req=0, err=0; a new burst is accepted normally.

Source files
------------

// File: rtl/fv_stream_buffer_pkg.sv
// rtl/fv_stream_buffer_pkg.sv - shared types and sizes for the FV stream buffer
package fv_stream_buffer_pkg;

    localparam int FV_BW_DEF     = 16;
    localparam int NUM_PE_DEF    = 4;
    localparam int DEPTH_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int TAG_W         = $clog2(NUM_PE_DEF);
    localparam int CNT_W         = $clog2(DEPTH_DEF) + 1;

    typedef struct packed {
        logic             sos;
        logic             eos;
        logic [TAG_W-1:0] PE_tag;
        logic [FV_BW_DEF-1:0] FV_data;
    } fv_buf_entry_t;

    typedef enum logic {
        IDLE,
        IN_BURST
    } burst_state_t;

endpackage

// File: rtl/fv_buf_fifo.sv
// rtl/fv_buf_fifo.sv - generic synchronous FIFO with occupancy count
module fv_buf_fifo #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fv_stream_buffer.sv
// rtl/fv_stream_buffer.sv - FV burst elastic buffer with per-PE routing; optional checker under FV_BUF_ERR_EN
module fv_stream_buffer
    import fv_stream_buffer_pkg::*;
#(
    parameter int FV_BW     = FV_BW_DEF,
    parameter int NUM_PE    = NUM_PE_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sos,
    input  logic              in_eos,
    input  logic [TAG_W-1:0]  in_PE_tag,
    input  logic [FV_BW-1:0]  in_FV_data,
    output logic [NUM_PE-1:0] pe_valid,
    output logic              pe_sos,
    output logic              pe_eos,
    output logic [FV_BW-1:0]  pe_FV_data,
    input  logic [NUM_PE-1:0] pe_ready,
    output logic              stall_req,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    fv_buf_entry_t wr_entry;
    fv_buf_entry_t head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;

    assign wr_entry = '{sos: in_sos, eos: in_eos, PE_tag: in_PE_tag, FV_data: in_FV_data};

    fv_buf_fifo #(
        .entry_t (fv_buf_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        pe_valid = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            pe_valid[i] = !empty && (head.PE_tag == TAG_W'(i));
        end
    end

    assign pe_sos     = head.sos;
    assign pe_eos     = head.eos;
    assign pe_FV_data = head.FV_data;
    assign pop        = |(pe_valid & pe_ready);
    assign push       = in_valid && (!full || pop);

    // Bursts cannot be throttled once started, so demand room for a whole burst.
    assign stall_req  = (CNT_W'(DEPTH) - count) < CNT_W'(MAX_BURST);

`ifdef FV_BUF_ERR_EN
    burst_state_t     state;
    burst_state_t     state_nxt;
    logic [TAG_W-1:0] burst_tag;
    logic             err_q;
    logic             err_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_tag <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_q | err_set;
            if (in_valid && in_sos) burst_tag <= in_PE_tag;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = in_valid && full && !pop;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!in_sos) err_set = 1'b1;
                    if (in_sos && !in_eos) state_nxt = IN_BURST;
                end
            end
            IN_BURST: begin
                if (in_valid) begin
                    if (in_sos || (in_PE_tag != burst_tag)) err_set = 1'b1;
                    if (in_eos) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fv_stream_buffer.sv
// tb/tb_fv_stream_buffer.sv - scoreboard bench for fv_stream_buffer
module tb_fv_stream_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sos;
    logic        in_eos;
    logic [1:0]  in_PE_tag;
    logic [15:0] in_FV_data;
    logic [3:0]  pe_valid;
    logic        pe_sos;
    logic        pe_eos;
    logic [15:0] pe_FV_data;
    logic [3:0]  pe_ready;
    logic        stall_req;
    logic [3:0]  count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] sb [$];

`ifdef FV_BUF_ERR_EN
    localparam logic EXP_DROP_ERR = 1'b1;
`else
    localparam logic EXP_DROP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    fv_stream_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sos     (in_sos),
        .in_eos     (in_eos),
        .in_PE_tag  (in_PE_tag),
        .in_FV_data (in_FV_data),
        .pe_valid   (pe_valid),
        .pe_sos     (pe_sos),
        .pe_eos     (pe_eos),
        .pe_FV_data (pe_FV_data),
        .pe_ready   (pe_ready),
        .stall_req  (stall_req),
        .count      (count),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] tag, input logic sos, input logic eos,
                        input logic [15:0] data, input logic accept);
        in_valid   = 1'b1;
        in_sos     = sos;
        in_eos     = eos;
        in_PE_tag  = tag;
        in_FV_data = data;
        if (accept) sb.push_back({sos, eos, tag, data});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int limit, input logic rnd);
        for (int k = 0; k < limit && count != 0; k++) begin
            if (rnd) pe_ready = 4'($urandom);
            tick();
        end
        check("drain_count", 32'(count), 0);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    // Monitor: compare the presented head against the scoreboard every cycle, retire on handshake.
    always @(negedge clk) begin
        if (!reset && pe_valid != 4'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_head", {10'b0, pe_valid, pe_sos, pe_eos, pe_FV_data}, 0);
            end else begin
                logic [19:0] e;
                logic [3:0]  onehot;
                e = sb[0];
                onehot = 4'b0001 << e[17:16];
                check("head", {10'b0, pe_valid, pe_sos, pe_eos, pe_FV_data},
                      {10'b0, onehot, e[19], e[18], e[15:0]});
                if ((pe_valid & pe_ready) != 4'b0) void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sos     = 1'b0;
        in_eos     = 1'b0;
        in_PE_tag  = 2'd0;
        in_FV_data = 16'h0;
        pe_ready   = 4'b0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_pe_valid", 32'(pe_valid), 0);
        check("rst_stall", 32'(stall_req), 0);
        check("rst_err", 32'(err), 0);

        // 4-word burst to PE 2, drained as it arrives
        pe_ready = 4'b0100;
        send(2'd2, 1'b1, 1'b0, 16'h0011, 1'b1);
        check("t1_first_valid", 32'(pe_valid), 32'h4);
        send(2'd2, 1'b0, 1'b0, 16'h0022, 1'b1);
        send(2'd2, 1'b0, 1'b0, 16'h0033, 1'b1);
        send(2'd2, 1'b0, 1'b1, 16'h0044, 1'b1);
        wait_empty(20, 1'b0);

        // Tag-1 burst drains, tag-3 head blocks until PE 3 is ready
        pe_ready = 4'b0010;
        send(2'd1, 1'b1, 1'b0, 16'h00A1, 1'b1);
        send(2'd1, 1'b0, 1'b1, 16'h00A2, 1'b1);
        send(2'd3, 1'b1, 1'b0, 16'h00B1, 1'b1);
        send(2'd3, 1'b0, 1'b1, 16'h00B2, 1'b1);
        repeat (2) tick();
        check("t2_blocked_valid", 32'(pe_valid), 32'h8);
        check("t2_blocked_data", 32'(pe_FV_data), 32'h00B1);
        check("t2_blocked_count", 32'(count), 2);
        pe_ready = 4'b1000;
        wait_empty(20, 1'b0);

        // stall_req threshold
        pe_ready = 4'b0000;
        send(2'd0, 1'b1, 1'b0, 16'h00C0, 1'b1);
        send(2'd0, 1'b0, 1'b0, 16'h00C1, 1'b1);
        send(2'd0, 1'b0, 1'b0, 16'h00C2, 1'b1);
        send(2'd0, 1'b0, 1'b1, 16'h00C3, 1'b1);
        check("t3_count4", 32'(count), 4);
        check("t3_stall_at4", 32'(stall_req), 0);
        send(2'd0, 1'b1, 1'b1, 16'h00C4, 1'b1);
        check("t3_count5", 32'(count), 5);
        check("t3_stall_at5", 32'(stall_req), 1);
        pe_ready = 4'b0001;
        tick();
        pe_ready = 4'b0000;
        check("t3_count_pop", 32'(count), 4);
        check("t3_stall_pop", 32'(stall_req), 0);

        // Full: push with simultaneous pop, then a dropped word
        for (int i = 0; i < 4; i++) send(2'd0, 1'b1, 1'b1, 16'h00D0 + 16'(i), 1'b1);
        check("t4_full_count", 32'(count), 8);
        check("t4_full_stall", 32'(stall_req), 1);
        pe_ready = 4'b0001;
        send(2'd0, 1'b1, 1'b1, 16'h00E0, 1'b1);
        pe_ready = 4'b0000;
        check("t4_pushpop_count", 32'(count), 8);
        check("t4_pushpop_err", 32'(err), 0);
        send(2'd0, 1'b1, 1'b1, 16'h00F0, 1'b0);
        check("t4_drop_count", 32'(count), 8);
        check("t4_drop_err", 32'(err), 32'(EXP_DROP_ERR));
        pe_ready = 4'b1111;
        wait_empty(40, 1'b0);
        do_reset();

        // Wrap-around: 20 single-word bursts with random ready
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 50 && stall_req; k++) begin
                pe_ready = 4'($urandom);
                tick();
            end
            pe_ready = 4'($urandom);
            send(2'(i % 4), 1'b1, 1'b1, 16'h0100 + 16'(i), 1'b1);
        end
        wait_empty(400, 1'b1);
        check("t5_err", 32'(err), 0);

        // Reset in the middle of a burst
        pe_ready = 4'b0000;
        send(2'd1, 1'b1, 1'b0, 16'h0200, 1'b1);
        send(2'd1, 1'b0, 1'b0, 16'h0201, 1'b1);
        send(2'd1, 1'b0, 1'b0, 16'h0202, 1'b1);
        check("t6_count3", 32'(count), 3);
        in_valid   = 1'b1;
        in_sos     = 1'b0;
        in_eos     = 1'b1;
        in_FV_data = 16'h0203;
        do_reset();
        in_valid = 1'b0;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_valid", 32'(pe_valid), 0);
        check("t6_rst_stall", 32'(stall_req), 0);
        check("t6_rst_err", 32'(err), 0);
        pe_ready = 4'b0100;
        send(2'd2, 1'b1, 1'b0, 16'h0300, 1'b1);
        check("t6_new_valid", 32'(pe_valid), 32'h4);
        send(2'd2, 1'b0, 1'b1, 16'h0301, 1'b1);
        wait_empty(20, 1'b0);
        check("t6_new_err", 32'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
